// File: rtl/acia6850_uart.sv
// 6850-compatible ACIA: CPU register interface, control decoding, RX/TX bit engines
// driven from a shared oversample tick, and RX (error-tagged) / TX FIFOs.
module acia6850_uart #(
    parameter int unsigned CLK_DIV       = 16,
    parameter int unsigned RX_DEPTH_BITS = 4,
    parameter int unsigned TX_DEPTH_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       addr,
    input  logic       ds,
    input  logic       rw,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       ser_in,
    output logic       ser_out,
    input  logic       cts_n,
    output logic       rts_n
);
    localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_BITS;
    localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_BITS;
    localparam int unsigned TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2} tx_state_e;

    // Word format decode of CR[4:2]
    function automatic logic fmt_len8(input logic [2:0] f);
        return f[2];
    endfunction
    function automatic logic fmt_par(input logic [2:0] f);
        return ~(f[2] & ~f[1]);
    endfunction
    function automatic logic fmt_odd(input logic [2:0] f);
        return f[0];
    endfunction
    function automatic logic fmt_stop2(input logic [2:0] f);
        return ~f[1] & (~f[2] | ~f[0]);
    endfunction

    // Oversample tick
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;
    assign tick = (tick_cnt_q == TICK_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt_q <= '0;
        else               tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Bus access edges
    logic acc, acc_q, rd_flag_q, wr_stb, rd_end;
    assign acc    = sel & ~ds;
    assign wr_stb = acc & ~acc_q & ~rw;
    assign rd_end = rd_flag_q & ~acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= 1'b0;
            rd_flag_q <= 1'b0;
        end else begin
            acc_q     <= acc;
            rd_flag_q <= acc & rw & addr;
        end
    end

    // Control register
    logic [7:0] cr_q;
    logic       mr, div64, tie, brk, rie;

    always_ff @(posedge clk) begin
        if (reset)                cr_q <= 8'h15;
        else if (wr_stb && !addr) cr_q <= din;
    end

    assign mr    = (cr_q[1:0] == 2'b11);
    assign div64 = (cr_q[1:0] == 2'b10);
    assign tie   = (cr_q[6:5] == 2'b01);
    assign brk   = (cr_q[6:5] == 2'b11);
    assign rts_n = (cr_q[6:5] == 2'b10);
    assign rie   = cr_q[7];

    // RX synchronizer
    logic rx_meta_q, rx_s_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= ser_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // RX FIFO state
    logic [9:0]               rx_mem [RX_DEPTH];
    logic [RX_DEPTH_BITS-1:0] rx_wp_q, rx_rp_q;
    logic [RX_DEPTH_BITS:0]   rx_count_q;
    logic                     rx_empty, rx_full, rx_pop, rx_wr, rx_push, ovrn_q;
    logic [9:0]               rx_wdata, rx_head;
    logic [7:0]               last_q;

    // RX engine
    rx_state_e  rx_st_q, rx_st_d;
    logic [5:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d, rx_fmt_q, rx_fmt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       rx_pe_q, rx_pe_d, rx_div64_q, rx_div64_d, rx_bit_end;
    logic [5:0] rx_half;

    assign rx_half    = rx_div64_q ? 6'd31 : 6'd7;
    assign rx_bit_end = (rx_cnt_q == (rx_div64_q ? 6'd63 : 6'd15));

    always_ff @(posedge clk) begin
        if (reset || mr) begin
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_pe_q    <= 1'b0;
            rx_fmt_q   <= 3'b101;
            rx_div64_q <= 1'b0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_pe_q    <= rx_pe_d;
            rx_fmt_q   <= rx_fmt_d;
            rx_div64_q <= rx_div64_d;
        end
    end

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_pe_d    = rx_pe_q;
        rx_fmt_d   = rx_fmt_q;
        rx_div64_d = rx_div64_q;
        rx_push    = 1'b0;
        rx_wdata   = {rx_pe_q, ~rx_s_q, rx_sh_q};
        unique case (rx_st_q)
            RxIdle: begin
                // Format and divide are frozen per frame so CR writes apply to the next one
                if (tick && !rx_s_q) begin
                    rx_st_d    = RxStart;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_sh_d    = '0;
                    rx_pe_d    = 1'b0;
                    rx_fmt_d   = cr_q[4:2];
                    rx_div64_d = div64;
                end
            end
            RxStart: begin
                if (tick) begin
                    if (rx_cnt_q == rx_half) begin
                        rx_cnt_d = '0;
                        rx_st_d  = rx_s_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            RxData: begin
                if (tick) begin
                    if (rx_bit_end) begin
                        rx_cnt_d          = '0;
                        rx_sh_d[rx_bit_q] = rx_s_q;
                        if (rx_bit_q == (fmt_len8(rx_fmt_q) ? 3'd7 : 3'd6)) begin
                            rx_st_d = fmt_par(rx_fmt_q) ? RxParity : RxStop;
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            RxParity: begin
                if (tick) begin
                    if (rx_bit_end) begin
                        rx_cnt_d = '0;
                        rx_pe_d  = (^rx_sh_q) ^ rx_s_q ^ fmt_odd(rx_fmt_q);
                        rx_st_d  = RxStop;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            RxStop: begin
                if (tick) begin
                    if (rx_bit_end) begin
                        rx_push = 1'b1;
                        rx_st_d = RxIdle;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    // RX FIFO
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = rx_count_q[RX_DEPTH_BITS];
    assign rx_pop   = rd_end & ~rx_empty;
    assign rx_wr    = rx_push & ~rx_full;
    assign rx_head  = rx_mem[rx_rp_q];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp_q] <= rx_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || mr) begin
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_count_q <= '0;
            ovrn_q     <= 1'b0;
        end else begin
            if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
            rx_count_q <= rx_count_q + {{RX_DEPTH_BITS{1'b0}}, rx_wr}
                                     - {{RX_DEPTH_BITS{1'b0}}, rx_pop};
            if (rx_push && rx_full) ovrn_q <= 1'b1;
            else if (rd_end)        ovrn_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       last_q <= 8'h00;
        else if (rx_pop) last_q <= rx_head[7:0];
    end

    // TX FIFO
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_BITS-1:0] tx_wp_q, tx_rp_q;
    logic [TX_DEPTH_BITS:0]   tx_count_q;
    logic                     tx_empty, tx_full, tx_wr, tx_pop;
    logic [7:0]               tx_head;

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = tx_count_q[TX_DEPTH_BITS];
    assign tx_wr    = wr_stb & addr & ~tx_full;
    assign tx_head  = tx_mem[tx_rp_q];

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset || mr) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_count_q <= '0;
        end else begin
            if (tx_wr)  tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop) tx_rp_q <= tx_rp_q + 1'b1;
            tx_count_q <= tx_count_q + {{TX_DEPTH_BITS{1'b0}}, tx_wr}
                                     - {{TX_DEPTH_BITS{1'b0}}, tx_pop};
        end
    end

    // TX engine; frames start on a tick so every bit spans exactly one bit period
    tx_state_e  tx_st_q, tx_st_d;
    logic [5:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d, tx_fmt_q, tx_fmt_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_div64_q, tx_div64_d, tx_bit_end;

    assign tx_bit_end = tick & (tx_cnt_q == (tx_div64_q ? 6'd63 : 6'd15));

    always_ff @(posedge clk) begin
        if (reset || mr) begin
            tx_st_q    <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_fmt_q   <= 3'b101;
            tx_div64_q <= 1'b0;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_fmt_q   <= tx_fmt_d;
            tx_div64_q <= tx_div64_d;
        end
    end

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_fmt_d   = tx_fmt_q;
        tx_div64_d = tx_div64_q;
        tx_pop     = 1'b0;
        if (tick && tx_st_q != TxIdle) tx_cnt_d = tx_bit_end ? 6'd0 : tx_cnt_q + 1'b1;
        unique case (tx_st_q)
            TxIdle: begin
                if (tick && !tx_empty && !cts_n && !brk) begin
                    tx_st_d    = TxStart;
                    tx_pop     = 1'b1;
                    tx_sh_d    = fmt_len8(cr_q[4:2]) ? tx_head : {1'b0, tx_head[6:0]};
                    tx_fmt_d   = cr_q[4:2];
                    tx_div64_d = div64;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TxStart:  if (tx_bit_end) tx_st_d = TxData;
            TxData: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == (fmt_len8(tx_fmt_q) ? 3'd7 : 3'd6)) begin
                        tx_st_d = fmt_par(tx_fmt_q) ? TxParity : TxStop1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end
            end
            TxParity: if (tx_bit_end) tx_st_d = TxStop1;
            TxStop1:  if (tx_bit_end) tx_st_d = fmt_stop2(tx_fmt_q) ? TxStop2 : TxIdle;
            TxStop2:  if (tx_bit_end) tx_st_d = TxIdle;
            default:  tx_st_d = TxIdle;
        endcase
    end

    always_comb begin
        ser_out = 1'b1;
        unique case (tx_st_q)
            TxStart:  ser_out = 1'b0;
            TxData:   ser_out = tx_sh_q[tx_bit_q];
            TxParity: ser_out = (^tx_sh_q) ^ fmt_odd(tx_fmt_q);
            default:  ser_out = 1'b1;
        endcase
        if (brk) ser_out = 1'b0;
        if (mr)  ser_out = 1'b1;
    end

    // Status, interrupt and read data
    logic       tdre;
    logic [7:0] status;

    assign tdre   = ~tx_full & ~cts_n;
    assign irq    = (rie & (~rx_empty | ovrn_q)) | (tie & tdre);
    assign status = {irq, ~rx_empty & rx_head[9], ovrn_q, ~rx_empty & rx_head[8],
                     cts_n, 1'b0, tdre, ~rx_empty};

    always_comb begin
        dout = 8'h00;
        if (acc && rw) begin
            if (!addr)         dout = status;
            else if (rx_empty) dout = last_q;
            else               dout = rx_head[7:0];
        end
    end

endmodule

// File: doc/acia6850_uart.md
Name: acia6850_uart

Overview:
- Generalised single-channel 6850-compatible ACIA that replaces the fixed IKBD/MIDI logic.
- Adds real control-register decoding: clock divide, word format, parity, RTS/break and TX interrupt.
- Adds parametrised RX/TX FIFOs carrying framing, parity and overrun error status.
- Instantiated once per serial channel (IKBD, MIDI, and later ports) behind the ST bus decode.

Parameters:
- CLK_DIV, 16, clk cycles per oversample tick (8 MHz / 16 = 500 kHz; /16 gives 31250 baud).
- RX_DEPTH_BITS, 4, log2 of RX FIFO depth.
- TX_DEPTH_BITS, 4, log2 of TX FIFO depth.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sel  in  1  chip select.
- addr  in  1  0 = control/status, 1 = data.
- ds  in  1  data strobe, active-low.
- rw  in  1  1 = read, 0 = write.
- din  in  8  CPU write data.
- dout  out  8  CPU read data; 0 when not reading.
- irq  out  1  interrupt request, active-high.
- ser_in  in  1  serial receive line, idle high.
- ser_out  out  1  serial transmit line.
- cts_n  in  1  clear-to-send, active-low.
- rts_n  out  1  request-to-send, active-low.

Behaviour:
- Reset: reset is synchronous, active-high, on clk. It sets CR=8'h15 (÷16, 8N1, RTS low, no IRQs), empties both FIFOs, clears OVRN, sets TX idle and ser_out=1, rts_n=0, irq=0.
- Access edge: acc = sel & ~ds. A write is captured on the first clk cycle with acc=1 (rising edge of acc). An RX pop happens on the cycle acc falls after a data read. dout is combinational and stable for the whole access.
- CR[1:0] clock divide: 00 or 01 = 16 ticks per bit; 10 = 64 ticks per bit; 11 = master reset.
- Master reset holds FIFOs, OVRN and both shifters cleared and ser_out=1 for as long as CR[1:0]=11. Other CR bits still latch.
- CR[4:2] word format: 000 7E2, 001 7O2, 010 7E1, 011 7O1, 100 8N2, 101 8N1, 110 8E1, 111 8O1.
- CR[6:5] TX control: 00 RTS low, TIE=0; 01 RTS low, TIE=1; 10 RTS high, TIE=0; 11 RTS low, TIE=0, send break (ser_out=0 continuously; the TX FIFO is not drained).
- CR[7]: RIE.
- Status register (addr 0 read):
  - bit0 RDRF = RX FIFO not empty.
  - bit1 TDRE = TX FIFO not full, forced 0 while cts_n=1.
  - bit2 DCD = 0.
  - bit3 CTS = cts_n.
  - bit4 FE of head entry.
  - bit5 OVRN.
  - bit6 PE of head entry.
  - bit7 = irq.
- irq = (RIE & (RDRF | OVRN)) | (TIE & TDRE).
- Data read (addr 1): dout = head byte; 7-bit formats return bit7=0. Pop on access end if non-empty. An empty read returns the last-popped byte and does not move pointers. Any data read clears OVRN.
- Data write (addr 1): push din to the TX FIFO. A push while full is discarded silently.
- Tick: free-running counter, one pulse every CLK_DIV cycles.
- RX states: IDLE / START / DATA / PARITY / STOP.
  - ser_in goes through a 2-flop synchronizer.
  - IDLE: a 0 seen on a tick enters START.
  - START: sample at half a bit period. If the line is 1, treat as a glitch and return to IDLE.
  - DATA: 7 or 8 bits, LSB first, each sampled mid-bit.
  - PARITY: only when the format has parity; PE = mismatch.
  - STOP: check only the first stop bit; FE = sampled 0.
  - On STOP, push {PE, FE, data} into the RX FIFO.
  - If the RX FIFO is full, drop the byte and set OVRN.
  - A simultaneous push and pop on a non-full FIFO are both performed.
- TX states: IDLE / START / DATA / PARITY / STOP1 / STOP2.
  - Leaves IDLE only when the FIFO is non-empty, cts_n=0 and not in break.
  - The byte is popped on entering START.
  - Each state lasts one bit period.
  - ser_out=1 in IDLE and both STOP states.
  - cts_n rising mid-frame completes the current frame.
- FIFO pointers are RX_DEPTH_BITS / TX_DEPTH_BITS wide and wrap naturally. A separate count, one bit wider, distinguishes full from empty.
- A CR write changing the divide or format mid-frame takes effect at the next frame. A master reset mid-frame aborts it immediately.

Test Plan:
- Reset, then read status -> 8'h02 (TDRE=1, rest 0). ser_out=1, rts_n=0, irq=0.
- Write CR=8'h95, feed ser_in frame 0xA5 in 8N1 at 256 clk/bit -> after the stop-bit sample RDRF=1, irq=1. Data read returns 8'hA5; after access end RDRF=0, irq=0.
- CR=8'h09 (7E1), TX write 0x41 -> ser_out exactly: 0, 1,0,0,0,0,0,1, 0 (even parity), 1, each lasting 256 clk. The TX FIFO drains 1 -> 0.
- Receive 17 bytes without reading (depth 16) -> OVRN=1 and the first 16 bytes are read back intact. The first data read clears OVRN.
- Receive 0x55 with stop bit 0 in 8E1 -> status FE=1. Separately, a wrong parity bit -> PE=1. Popping that entry clears FE/PE.
- Hold cts_n=1 with TX FIFO loaded -> ser_out stays 1, TDRE=0. Release -> frame starts within one bit period. Write CR[1:0]=11 mid-frame -> ser_out=1 next cycle, FIFOs empty.
